// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the imem/dmem memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } owner_t;

    // Width of the bus timeout counter; it must hold TIMEOUT_CYCLES-1.
    function automatic int to_width(input int timeout_cycles);
        return $clog2(timeout_cycles);
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts BUSY cycles without a bus acknowledge and flags the last allowed one.
module arb_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TO_W = to_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    // Cycle counter: cleared when a transaction is granted, advanced while waiting.
    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values of the others regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TO_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the instruction-fetch and data ports of the core.
// dmem wins contention until it has been granted MAX_DMEM_STREAK times in a row
// over a waiting imem; hung accesses complete with an error after TIMEOUT_CYCLES.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int MAX_DMEM_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                imem_req,
    input  logic [ADDR_W-1:0]   imem_addr,
    output logic [DATA_W-1:0]   imem_rdata,
    output logic                imem_ready,
    output logic                imem_err,
    input  logic                dmem_req,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_we,
    input  logic [DATA_W/8-1:0] dmem_be,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                dmem_ready,
    output logic                dmem_err,
    output logic                bus_req,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                arb_owner,
    output logic                arb_busy
);

    localparam int STREAK_W = $clog2(MAX_DMEM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DMEM_STREAK);

    arb_state_t          state;
    arb_state_t          state_nxt;
    owner_t              owner;
    logic [STREAK_W-1:0] streak;
    logic                err_q;
    logic                grant_imem;
    logic                grant_dmem;
    logic                expire;
    logic                complete;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decision; dmem yields only once its streak is exhausted.
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dmem_req && !(imem_req && streak == STREAK_MAX)) begin
                    grant_dmem = 1'b1;
                    state_nxt  = ARB_BUSY;
                end else if (imem_req) begin
                    grant_imem = 1'b1;
                    state_nxt  = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (bus_ack || expire) begin
                    state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // An ack in the final allowed cycle counts as a normal completion.
    assign complete = (state == ARB_BUSY) && (bus_ack || expire);

    // Consecutive dmem grants that made imem wait; any other grant resets it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant_imem) begin
            streak <= '0;
        end else if (grant_dmem) begin
            if (!imem_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end

    // Bus request fields captured at grant, response data captured at completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            owner      <= OWN_IMEM;
            err_q      <= 1'b0;
            imem_rdata <= '0;
            dmem_rdata <= '0;
        end else begin
            if (grant_dmem) begin
                bus_addr  <= dmem_addr;
                bus_wdata <= dmem_wdata;
                bus_we    <= dmem_we;
                bus_be    <= dmem_be;
                owner     <= OWN_DMEM;
            end else if (grant_imem) begin
                bus_addr  <= imem_addr;
                bus_wdata <= '0;
                bus_we    <= 1'b0;
                bus_be    <= '1;
                owner     <= OWN_IMEM;
            end
            if (complete) begin
                err_q <= !bus_ack;
                if (owner == OWN_DMEM) begin
                    dmem_rdata <= bus_ack ? bus_rdata : '0;
                end else begin
                    imem_rdata <= bus_ack ? bus_rdata : '0;
                end
            end
        end
    end

    arb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (grant_imem | grant_dmem),
        .en     ((state == ARB_BUSY) && !bus_ack),
        .expire (expire)
    );

    assign bus_req    = (state == ARB_BUSY);
    assign arb_busy   = (state != ARB_IDLE);
    assign arb_owner  = owner;
    assign imem_ready = (state == ARB_RESP) && (owner == OWN_IMEM);
    assign dmem_ready = (state == ARB_RESP) && (owner == OWN_DMEM);
    assign imem_err   = imem_ready && err_q;
    assign dmem_err   = dmem_ready && err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one external memory port between the core's instruction-fetch (imem) and data (dmem) interfaces, for single-ported memory configurations of the RV32I pipeline.
Grants one requester at a time with one outstanding transaction. dmem has priority by default; an anti-starvation limit guarantees imem progress.
Enforces a bus timeout that completes a hung access with an error flag. Sits between the core's imem/dmem ports and the unified memory bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables = DATA_W/8)
TIMEOUT_CYCLES, 256, maximum BUSY cycles without bus_ack before error completion (>=2)
MAX_DMEM_STREAK, 4, consecutive dmem grants allowed while imem is waiting (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
imem_req  in  1  fetch request, held until imem_ready
imem_addr  in  ADDR_W  fetch address
imem_rdata  out  DATA_W  fetch data, valid with imem_ready
imem_ready  out  1  one-cycle completion pulse
imem_err  out  1  timeout flag, valid with imem_ready
dmem_req  in  1  data request, held until dmem_ready
dmem_addr  in  ADDR_W  data address
dmem_wdata  in  DATA_W  store data
dmem_we  in  1  1 = store
dmem_be  in  DATA_W/8  byte enables
dmem_rdata  out  DATA_W  load data, valid with dmem_ready
dmem_ready  out  1  one-cycle completion pulse
dmem_err  out  1  timeout flag, valid with dmem_ready
bus_req  out  1  bus request, held until bus_ack
bus_addr  out  ADDR_W  registered address
bus_wdata  out  DATA_W  registered store data
bus_we  out  1  registered write enable (0 for imem)
bus_be  out  DATA_W/8  registered byte enables (all ones for imem)
bus_ack  in  1  slave completion, one cycle
bus_rdata  in  DATA_W  read data, valid with bus_ack
arb_owner  out  1  current/last owner: 0 = imem, 1 = dmem
arb_busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- While rst_n=0 at a clk edge: state=IDLE, streak=0, timeout count=0, all outputs 0.
- Reset during BUSY drops bus_req at that edge and suppresses the pending ready pulse.
- States: IDLE, BUSY, RESP.
- IDLE, grant rule:
  - If no request is pending, stay in IDLE.
  - If only one requester is pending, grant it.
  - If both are pending, grant dmem unless streak==MAX_DMEM_STREAK; in that case grant imem.
- IDLE, at the grant edge: latch addr/wdata/we/be (imem: we=0, be=all ones) into bus_* registers, set arb_owner, enter BUSY.
- Streak counter:
  - Increments on a dmem grant made while imem_req=1.
  - Clears on any imem grant, and on a dmem grant made while imem_req=0.
  - Saturates at MAX_DMEM_STREAK.
- BUSY:
  - bus_req=1 and bus_* are stable.
  - bus_ack=1 → register bus_rdata into the owner's rdata, err=0, go to RESP.
  - Otherwise the timeout count increments.
  - If count==TIMEOUT_CYCLES-1 with no ack: owner rdata=0, err=1, go to RESP. BUSY therefore lasts at most TIMEOUT_CYCLES cycles.
  - An ack in that final cycle wins over the timeout.
  - The count clears on entry to BUSY.
- RESP:
  - The owner's ready=1 for exactly one cycle; bus_req=0; next state is IDLE.
  - Non-owner ready/err stay 0.
  - rdata holds its value until the next completion for that requester.
- Requester rule: req must stay asserted, with stable fields, until ready. If req is still high in the IDLE cycle after RESP, it is treated as a new request.
- Minimum latency: req seen in IDLE at cycle 0; bus_req at cycle 1; ack at cycle 1 gives ready at cycle 2.
- Throughput: one transaction per 3 cycles minimum.
- A requester deasserting req in BUSY/RESP does not abort the transaction. Its completion is still delivered.
- arb_busy = (state != IDLE), combinational from state.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_RESP}
  - owner_t enum {OWN_IMEM=0, OWN_DMEM=1}
  - localparam TO_W = $clog2(TIMEOUT_CYCLES)
- One sub-module, arb_timeout_counter. Inputs: clr, en. Output: expire when count==TIMEOUT_CYCLES-1.
- Arbitration FSM and streak logic stay in the top.

Test Plan:
1. imem_req=1, imem_addr=0x0000_0040; bus_ack=1 in cycle 1 with bus_rdata=0x0000_0013 → bus_addr=0x40 and bus_we=0 in cycle 1; imem_ready=1 and imem_rdata=0x13 in cycle 2; imem_err=0.
2. imem_req and dmem_req both rise in cycle 0; slave acks immediately → dmem served first (ready at cycle 2); imem then granted (imem_ready at cycle 5); arb_owner 1 then 0.
3. dmem_req held high continuously, imem_req high, MAX_DMEM_STREAK=4 → four dmem completions, then imem granted on the 5th decision; streak then clears.
4. TIMEOUT_CYCLES=8, dmem load at 0x200, bus_ack never asserted → bus_req high for exactly 8 cycles; dmem_ready=1, dmem_err=1, dmem_rdata=0 on the next cycle.
5. dmem store: addr 0x100, wdata 0xCAFE_BABE, be=4'b0011, we=1; ack after 3 cycles → bus fields match and stay stable through BUSY; dmem_ready 1 cycle after ack; dmem_err=0.
6. rst_n=0 in the 2nd BUSY cycle of an imem fetch → state IDLE after that edge; bus_req=0; no imem_ready pulse; all outputs 0.
